// File: rtl/stream_framer.sv
// stream_framer: FIFO-buffered AXI4-Stream re-framer that inserts TLAST every FRAME_LEN words.
//
// Ports:
//   aclk, aresetn                     clock, synchronous active-low reset
//   in_V_V_TVALID/TREADY/TDATA        upstream 32-bit word stream (from the accelerator)
//   out_V_V_TVALID/TREADY/TDATA/TLAST framed 32-bit stream towards the DMA engine
//   fifo_level                        words currently buffered (0..DEPTH)
//   frame_count                       frames fully emitted since reset, wraps at 16 bits
//
// Optional feature: define STREAM_FRAMER_CHECKSUM_EN to append one XOR checksum word
// (carrying TLAST) after every FRAME_LEN data words.
module stream_framer #(
   parameter int DEPTH     = 16,
   parameter int FRAME_LEN = 64
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     in_V_V_TVALID,
   output logic                     in_V_V_TREADY,
   input  logic [31:0]              in_V_V_TDATA,
   output logic                     out_V_V_TVALID,
   input  logic                     out_V_V_TREADY,
   output logic [31:0]              out_V_V_TDATA,
   output logic                     out_V_V_TLAST,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [15:0]              frame_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
   logic [31:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0] level_q, level_d;
   logic [15:0] wcnt_q, wcnt_d, fcnt_q, fcnt_d;
   logic push, pop, at_last, frame_done;
   // Ready depends only on the registered level, so DMA stalls never reach upstream combinationally.
   assign in_V_V_TREADY = level_q != (AW+1)'(DEPTH);
   assign push = in_V_V_TVALID && in_V_V_TREADY;
   assign at_last = wcnt_q == LAST_IDX;
   assign fifo_level = level_q;
   assign frame_count = fcnt_q;
`ifdef STREAM_FRAMER_CHECKSUM_EN
   typedef enum logic {DATA, CSUM} state_t;
   state_t state_q, state_d;
   logic [31:0] csum_q, csum_d;
   assign out_V_V_TVALID = state_q == CSUM || level_q != '0;
   assign out_V_V_TDATA = state_q == CSUM ? csum_q : mem_q[rptr_q];
   assign out_V_V_TLAST = state_q == CSUM;
   assign pop = state_q == DATA && level_q != '0 && out_V_V_TREADY;
   assign frame_done = state_q == CSUM && out_V_V_TREADY;
   always_comb begin
      state_d = frame_done ? DATA : (pop && at_last) ? CSUM : state_q;
      csum_d = frame_done ? '0 : pop ? csum_q ^ mem_q[rptr_q] : csum_q;
   end
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= DATA;
         csum_q <= '0;
      end else begin
         state_q <= state_d;
         csum_q <= csum_d;
      end
   end
`else
   assign out_V_V_TVALID = level_q != '0;
   assign out_V_V_TDATA = mem_q[rptr_q];
   // Gated with TVALID so TLAST stays low while idle, even when FRAME_LEN is 1.
   assign out_V_V_TLAST = out_V_V_TVALID && at_last;
   assign pop = out_V_V_TVALID && out_V_V_TREADY;
   assign frame_done = pop && at_last;
`endif
   always_comb begin
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
      wcnt_d = pop ? (at_last ? '0 : wcnt_q + 16'd1) : wcnt_q;
      fcnt_d = fcnt_q + 16'(frame_done);
   end
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         level_q <= '0;
         wcnt_q <= '0;
         fcnt_q <= '0;
      end else begin
         wptr_q <= wptr_q + AW'(push);
         rptr_q <= rptr_q + AW'(pop);
         level_q <= level_d;
         wcnt_q <= wcnt_d;
         fcnt_q <= fcnt_d;
      end
   end
   always_ff @(posedge aclk) begin
      if (push) mem_q[wptr_q] <= in_V_V_TDATA;
   end
endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: directed self-checking bench for stream_framer.
module tb_stream_framer;
`ifdef STREAM_FRAMER_CHECKSUM_EN
   localparam bit CK = 1'b1;
   localparam int FL1 = 4;
   localparam int NB = 4;
   logic [31:0] b_in [5] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h0};
   logic [31:0] b_exp [5] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'hF};
   logic b_lst [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam int B_FC = 1;
`else
   localparam bit CK = 1'b0;
   localparam int FL1 = 1;
   localparam int NB = 5;
   logic [31:0] b_in [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
   logic [31:0] b_exp [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
   logic b_lst [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam int B_FC = 5;
`endif
   localparam int FL0 = 64;
   logic aclk = 1'b0, aresetn = 1'b0;
   logic a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0, a_ol;
   logic [31:0] a_id = '0, a_od;
   logic [4:0] a_lvl;
   logic [15:0] a_fc;
   logic b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0, b_ol;
   logic [31:0] b_id = '0, b_od;
   logic [3:0] b_lvl;
   logic [15:0] b_fc;
   int n_chk = 0, n_bad = 0, acc = 0, m_wcnt = 0, m_frames = 0;
   logic [31:0] q [$];
   logic m_cs = 1'b0, st_v = 1'b0, st_l = 1'b0;
   logic [31:0] m_x = '0, st_d = '0;

   always #5 aclk = ~aclk;

   stream_framer #(.DEPTH(16), .FRAME_LEN(FL0)) u0 (
      .aclk(aclk), .aresetn(aresetn),
      .in_V_V_TVALID(a_iv), .in_V_V_TREADY(a_ir), .in_V_V_TDATA(a_id),
      .out_V_V_TVALID(a_ov), .out_V_V_TREADY(a_or), .out_V_V_TDATA(a_od), .out_V_V_TLAST(a_ol),
      .fifo_level(a_lvl), .frame_count(a_fc));

   stream_framer #(.DEPTH(8), .FRAME_LEN(FL1)) u1 (
      .aclk(aclk), .aresetn(aresetn),
      .in_V_V_TVALID(b_iv), .in_V_V_TREADY(b_ir), .in_V_V_TDATA(b_id),
      .out_V_V_TVALID(b_ov), .out_V_V_TREADY(b_or), .out_V_V_TDATA(b_od), .out_V_V_TLAST(b_ol),
      .fifo_level(b_lvl), .frame_count(b_fc));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock of stimulus on u0, with the reference model tracking what u0 must emit.
   task automatic cyc(input logic v, input logic [31:0] d, input logic r);
      logic [31:0] e;
      @(negedge aclk);
      a_iv = v;
      a_id = d;
      a_or = r;
      #1;
      if (st_v) begin
         chk("stable_data", a_od, st_d);
         chk("stable_last", 32'(a_ol), 32'(st_l));
      end
      st_v = a_ov && !a_or;
      st_d = a_od;
      st_l = a_ol;
      if (a_iv && a_ir) begin
         q.push_back(d);
         acc++;
      end
      if (a_ov && a_or) begin
         if (m_cs) begin
            chk("csum_word", a_od, m_x);
            chk("csum_last", 32'(a_ol), 32'd1);
            m_cs = 1'b0;
            m_x = '0;
            m_frames++;
         end else if (q.size() == 0) begin
            chk("spurious_out", 32'(a_ov), 32'd0);
         end else begin
            e = q.pop_front();
            chk("data", a_od, e);
            chk("last", 32'(a_ol), 32'(!CK && m_wcnt == FL0 - 1));
            m_x ^= e;
            if (m_wcnt == FL0 - 1) begin
               m_wcnt = 0;
               if (CK) m_cs = 1'b1;
               else m_frames++;
            end else m_wcnt++;
         end
      end
   endtask

   task automatic drain();
      int k = 0;
      while ((q.size() != 0 || m_cs) && k < 300) begin
         cyc(1'b0, '0, 1'b1);
         k++;
      end
      chk("drain_timeout", 32'(k < 300), 32'd1);
      cyc(1'b0, '0, 1'b1);
   endtask

   task automatic rst_dut();
      @(negedge aclk);
      aresetn = 1'b0;
      a_iv = 1'b0;
      a_or = 1'b0;
      b_iv = 1'b0;
      b_or = 1'b0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      q.delete();
      m_wcnt = 0;
      m_cs = 1'b0;
      m_x = '0;
      m_frames = 0;
      st_v = 1'b0;
      #1;
   endtask

   initial begin
      logic tv;
      logic [31:0] td;
      int pre, n;
      rst_dut();
      chk("rst_in_ready", 32'(a_ir), 32'd1);
      chk("rst_out_valid", 32'(a_ov), 32'd0);
      chk("rst_last", 32'(a_ol), 32'd0);
      chk("rst_level", 32'(a_lvl), 32'd0);
      chk("rst_frames", 32'(a_fc), 32'd0);
      acc = 0;
      for (int c = 0; c < 200 && acc < 64; c++) begin
         cyc(1'b1, 32'(acc), 1'b1);
         if (c == 0) chk("lat_first_idle", 32'(a_ov), 32'd0);
         if (c == 1) chk("lat_first_out", 32'(a_ov), 32'd1);
      end
      chk("t1_accepted", 32'(acc), 32'd64);
      drain();
      chk("t1_frames", 32'(a_fc), 32'd1);
      chk("t1_level", 32'(a_lvl), 32'd0);
      acc = 0;
      for (int c = 0; c < 20; c++) cyc(1'b1, 32'(100 + acc), 1'b0);
      chk("full_accepted", 32'(acc), 32'd16);
      chk("full_in_ready", 32'(a_ir), 32'd0);
      chk("full_level", 32'(a_lvl), 32'd16);
      for (int c = 0; c < 100 && acc < 20; c++) begin
         cyc(1'b1, 32'(100 + acc), 1'b1);
         if (c == 0) chk("full_still_low", 32'(a_ir), 32'd0);
         if (c == 1) chk("full_recover", 32'(a_ir), 32'd1);
      end
      chk("t2_accepted", 32'(acc), 32'd20);
      drain();
      acc = 0;
      tv = 1'b0;
      td = '0;
      for (int c = 0; c < 20000 && acc < 1000; c++) begin
         if (!tv) begin
            tv = 1'($urandom_range(0, 1));
            td = $urandom;
         end
         pre = acc;
         cyc(tv, td, 1'($urandom_range(0, 1)));
         if (acc != pre) tv = 1'b0;
      end
      chk("t3_accepted", 32'(acc), 32'd1000);
      drain();
      chk("t3_frames", 32'(a_fc), 32'd16);
      rst_dut();
      acc = 0;
      for (int c = 0; c < 10; c++) cyc(1'b1, 32'(200 + acc), 1'b0);
      chk("mid_accepted", 32'(acc), 32'd10);
      rst_dut();
      chk("mid_rst_level", 32'(a_lvl), 32'd0);
      chk("mid_rst_valid", 32'(a_ov), 32'd0);
      acc = 0;
      for (int c = 0; c < 200 && acc < 64; c++) cyc(1'b1, 32'(300 + acc), 1'b1);
      drain();
      chk("mid_frames", 32'(a_fc), 32'd1);
      rst_dut();
      for (int k = 0; k < NB; k++) begin
         @(negedge aclk);
         b_iv = 1'b1;
         b_id = b_in[k];
      end
      @(negedge aclk);
      b_iv = 1'b0;
      #1;
      chk("b_level", 32'(b_lvl), 32'(NB));
      b_or = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && n < 5; c++) begin
         if (b_ov) begin
            chk("b_data", b_od, b_exp[n]);
            chk("b_last", 32'(b_ol), 32'(b_lst[n]));
            n++;
         end
         @(negedge aclk);
         #1;
      end
      chk("b_count", 32'(n), 32'd5);
      chk("b_frames", 32'(b_fc), 32'(B_FC));
      chk("b_level_end", 32'(b_lvl), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/stream_framer.md
# stream_framer

Downstream stage of the accelerator top: consumes the 32-bit `output_V_V` AXI4-Stream words produced by the accelerator and buffers them in a small FIFO. Re-emits them as a framed AXI4-Stream with TLAST for the DMA engine, asserting TLAST every FRAME_LEN words. It decouples accelerator back-pressure from DMA stalls and reports simple frame/occupancy status.

## Interface
- DEPTH, 16, FIFO depth in words; power of two, ≥2
- FRAME_LEN, 64, data words per frame; 1..65535
- aclk  in  1  single clock, all logic rising-edge
- aresetn  in  1  reset: synchronous, active-low
- in_V_V_TVALID  in  1  upstream word valid (from accelerator output_V_V_TVALID)
- in_V_V_TREADY  out  1  framer can accept a word
- in_V_V_TDATA  in  32  upstream word
- out_V_V_TVALID  out  1  framed word valid
- out_V_V_TREADY  in  1  DMA accepts word
- out_V_V_TDATA  out  32  framed word
- out_V_V_TLAST  out  1  last word of current frame
- fifo_level  out  clog2(DEPTH)+1  words currently stored
- frame_count  out  16  frames fully emitted since reset, wraps 65535→0

## Operation
- Handshake: transfer occurs on a cycle where TVALID && TREADY at the rising edge; both sides follow AXI4-Stream.
- FIFO: circular buffer, write/read pointers of clog2(DEPTH) bits wrapping DEPTH-1→0, separate occupancy counter.
- in_V_V_TREADY = (fifo_level != DEPTH); combinational from the registered count only, never from out_V_V_TREADY.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Push when full: impossible (TREADY low); pop when empty: impossible (TVALID low in DATA state).
- Word counter `wcnt` (16 bits) counts data words popped in current frame, 0..FRAME_LEN-1.
- State machine (two states):
  - DATA: out_V_V_TVALID = (fifo_level != 0); TDATA = FIFO head. On pop: if wcnt == FRAME_LEN-1, wcnt→0 and end of frame (see Configuration), else wcnt+1.
  - CSUM: only exists with checksum enabled; see Configuration.
- TLAST asserted in DATA state iff wcnt == FRAME_LEN-1 (checksum disabled).
- frame_count increments on the handshake of the TLAST word.
- Output stability: while out_V_V_TVALID && !out_V_V_TREADY, TDATA and TLAST do not change.
- No data is dropped, reordered or duplicated.

## Timing
- Reset (aresetn low at a rising edge): pointers, fifo_level, wcnt, frame_count = 0; state = DATA; out_V_V_TVALID = 0, out_V_V_TLAST = 0, in_V_V_TREADY = 1 from the first cycle after release. TDATA is don't-care while TVALID = 0.
- Reset mid-frame: partial frame and buffered words discarded; the next accepted word starts frame at wcnt = 0.
- Latency: word accepted at edge N is presented on out_V_V_TDATA with TVALID high in cycle N+1 at the earliest; no combinational in→out path.
- Throughput: one word per cycle sustained in both directions when not full and out_V_V_TREADY high.
- Full recovery: pop at edge N with level = DEPTH → in_V_V_TREADY high in cycle N+1.
- FRAME_LEN = 1: every data word carries TLAST.

## Configuration
- Macro `STREAM_FRAMER_CHECKSUM_EN`.
- Defined: running XOR `csum` (32 bits) accumulates each popped data word, cleared at frame start. After the pop with wcnt == FRAME_LEN-1 → state CSUM. In CSUM: out_V_V_TVALID = 1, TDATA = final XOR of frame, TLAST = 1; FIFO not read, pushes continue. On handshake → DATA, csum = 0, frame_count+1. Data words never carry TLAST. Frame = FRAME_LEN+1 words.
- Undefined: no CSUM state, no csum register; frame = FRAME_LEN words with TLAST on last data word.

## Test plan
- Reset then 64 words 0..63, out_V_V_TREADY=1 (default params, checksum off) → 64 outputs 0..63 in order, TLAST only on 63, frame_count=1, first output one cycle after first accept.
- out_V_V_TREADY=0, push 20 words → 16 accepted, in_V_V_TREADY low, fifo_level=16; raise TREADY → in_V_V_TREADY high next cycle, all 20 emerge in order.
- Random TVALID/TREADY toggling, 1000 words → output sequence identical to input, TDATA/TLAST stable during every stall.
- FRAME_LEN=1, 5 words → TLAST on every word, frame_count=5.
- Checksum on, FRAME_LEN=4, words 0x1,0x2,0x4,0x8 → 5 outputs, fifth = 0xF with TLAST, data words TLAST=0.
- aresetn low after 10 of 64 words → level 0, TVALID 0; next 64 words form a complete frame with TLAST on 64th.
